// File: rtl/cellrv32_package.sv
// cellrv32_package: shared types and helpers for the cellrv32 FIFO drain
package cellrv32_package;

    typedef enum logic [1:0] {
        DRAIN_IDLE,
        DRAIN_WAIT,
        DRAIN_SEND
    } drain_state_t;

    // number of bits needed to index n entries
    function automatic int index_size_f(input int n);
        int r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cellrv32_fifo_drain.sv
// cellrv32_fifo_drain: pops FIFO words and streams each one out as narrower valid/ready beats
module cellrv32_fifo_drain
    import cellrv32_package::*;
#(
    parameter int   WORD_WIDTH = 32,
    parameter int   BEAT_WIDTH = 8,
    parameter logic FIFO_RSYNC = 1'b0,
    parameter logic MSB_FIRST  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  clear_i,
    input  logic                  fifo_avail_i,
    output logic                  fifo_re_o,
    input  logic [WORD_WIDTH-1:0] fifo_rdata_i,
    output logic [BEAT_WIDTH-1:0] tx_data_o,
    output logic                  tx_valid_o,
    input  logic                  tx_ready_i,
    output logic                  tx_last_o,
    output logic                  busy_o
);

    localparam int RATIO = (BEAT_WIDTH == 0) ? 1 : WORD_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (index_size_f(RATIO) < 1) ? 1 : index_size_f(RATIO);

    if ((BEAT_WIDTH == 0) || (WORD_WIDTH % ((BEAT_WIDTH == 0) ? 1 : BEAT_WIDTH) != 0)) begin : g_bad_width
        $error("cellrv32_fifo_drain: WORD_WIDTH must be a non-zero multiple of BEAT_WIDTH");
    end

    drain_state_t          state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [WORD_WIDTH-1:0] word;
    logic                  last, hs, cap;

    // state, beat counter and held word; clear discards the word and restarts at beat 0
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state <= DRAIN_IDLE;
            cnt   <= '0;
            word  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (clear_i || (hs && last)) ? '0 : hs ? cnt + CNT_W'(1) : cnt;
            word  <= clear_i ? '0 : cap ? fifo_rdata_i : word;
        end
    end

    // a finished word either chains straight into the next pop or falls back to idle
    always_comb begin
        state_nxt = clear_i                                 ? DRAIN_IDLE :
                    (state == DRAIN_WAIT)                   ? DRAIN_SEND :
                    (state == DRAIN_SEND && !(hs && last))  ? DRAIN_SEND :
                    fifo_re_o ? (FIFO_RSYNC ? DRAIN_WAIT : DRAIN_SEND) : DRAIN_IDLE;
    end

    // handshake and pop strobes; popping is gated by reset so nothing leaves the FIFO while held in reset
    always_comb begin
        last       = cnt == CNT_W'(RATIO - 1);
        tx_valid_o = state == DRAIN_SEND;
        tx_last_o  = tx_valid_o && last;
        busy_o     = state != DRAIN_IDLE;
        hs         = tx_valid_o && tx_ready_i;
        fifo_re_o  = rstn_i && !clear_i && fifo_avail_i && (state == DRAIN_IDLE || (hs && last));
        cap        = (fifo_re_o && !FIFO_RSYNC) || (state == DRAIN_WAIT);
    end

    // pick the current beat out of the held word, lowest or highest slice first
    always_comb begin
        tx_data_o = BEAT_WIDTH'(word >> (BEAT_WIDTH * (MSB_FIRST ? RATIO - 1 - int'(cnt) : int'(cnt))));
    end

endmodule

// File: tb/tb_cellrv32_fifo_drain.sv
// tb_cellrv32_fifo_drain: directed vector bench for the FIFO drain in three configurations
module tb_cellrv32_fifo_drain;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    // instance A: async-read FIFO, 32->8, LSB first; instance B: sync-read FIFO, 32->8, MSB first
    logic        pa, pb, rdy_a, rdy_b, clr_a, clr_b;
    logic [31:0] da, db;
    logic        re_a, re_b, va, vb, la, lb, ba, bb;
    logic [7:0]  ta, tb_d;
    logic        avail_a, avail_b;
    logic [31:0] rdata_a, rdb;

    // instance C: 16->16, driven directly
    logic        avc, rdyc, clrc, rec, vc, lc, bc;
    logic [15:0] rdc, tc;

    // depth-4 FIFO models feeding A and B
    logic [31:0] ma[4], mb[4];
    logic [1:0]  wa, ra, wb, rb;
    int          ca, cb;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wa <= 0; ra <= 0; ca <= 0;
            wb <= 0; rb <= 0; cb <= 0;
            rdb <= 0;
        end else begin
            if (pa && ca < 4) begin ma[wa] <= da; wa <= wa + 1; end
            if (re_a && ca > 0) ra <= ra + 1;
            ca <= ca + int'(pa && ca < 4) - int'(re_a && ca > 0);
            if (pb && cb < 4) begin mb[wb] <= db; wb <= wb + 1; end
            if (re_b && cb > 0) begin rb <= rb + 1; rdb <= mb[rb]; end
            cb <= cb + int'(pb && cb < 4) - int'(re_b && cb > 0);
        end
    end

    assign avail_a = ca != 0;
    assign avail_b = cb != 0;
    assign rdata_a = ma[ra];

    cellrv32_fifo_drain #(.WORD_WIDTH(32), .BEAT_WIDTH(8), .FIFO_RSYNC(1'b0), .MSB_FIRST(1'b0)) u_a (
        .clk_i(clk), .rstn_i(rstn), .clear_i(clr_a), .fifo_avail_i(avail_a), .fifo_re_o(re_a),
        .fifo_rdata_i(rdata_a), .tx_data_o(ta), .tx_valid_o(va), .tx_ready_i(rdy_a),
        .tx_last_o(la), .busy_o(ba)
    );

    cellrv32_fifo_drain #(.WORD_WIDTH(32), .BEAT_WIDTH(8), .FIFO_RSYNC(1'b1), .MSB_FIRST(1'b1)) u_b (
        .clk_i(clk), .rstn_i(rstn), .clear_i(clr_b), .fifo_avail_i(avail_b), .fifo_re_o(re_b),
        .fifo_rdata_i(rdb), .tx_data_o(tb_d), .tx_valid_o(vb), .tx_ready_i(rdy_b),
        .tx_last_o(lb), .busy_o(bb)
    );

    cellrv32_fifo_drain #(.WORD_WIDTH(16), .BEAT_WIDTH(16), .FIFO_RSYNC(1'b0), .MSB_FIRST(1'b0)) u_c (
        .clk_i(clk), .rstn_i(rstn), .clear_i(clrc), .fifo_avail_i(avc), .fifo_re_o(rec),
        .fifo_rdata_i(rdc), .tx_data_o(tc), .tx_valid_o(vc), .tx_ready_i(rdyc),
        .tx_last_o(lc), .busy_o(bc)
    );

    typedef struct {
        logic        sel;
        logic        push;
        logic [31:0] pd;
        logic        rdy;
        logic        clr;
        logic        e_re;
        logic        e_v;
        logic [7:0]  e_d;
        logic        e_l;
        logic        e_b;
    } vec_t;

    vec_t vt[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic row(input logic sel, input logic push, input logic [31:0] pd, input logic rdy,
                       input logic clr, input logic e_re, input logic e_v, input logic [7:0] e_d,
                       input logic e_l, input logic e_b);
        vec_t v;
        v.sel = sel; v.push = push; v.pd = pd; v.rdy = rdy; v.clr = clr;
        v.e_re = e_re; v.e_v = e_v; v.e_d = e_d; v.e_l = e_l; v.e_b = e_b;
        vt.push_back(v);
    endtask

    task automatic idle_rows(input logic sel, input int n);
        for (int i = 0; i < n; i++) row(sel, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        pa = 0; pb = 0; da = 0; db = 0;
        rdy_a = 1; rdy_b = 1; clr_a = 0; clr_b = 0;
        avc = 1; rdc = 16'h1234; rdyc = 1; clrc = 0;

        // A: two words back to back, no bubble
        row(0, 1, 32'hAABBCCDD, 1, 0, 0, 0, 0,     0, 0);
        row(0, 1, 32'h11223344, 1, 0, 1, 0, 0,     0, 0);
        row(0, 0, 0,            1, 0, 0, 1, 'hDD, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'hCC, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'hBB, 0, 1);
        row(0, 0, 0,            1, 0, 1, 1, 'hAA, 1, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h44, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h33, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h22, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h11, 1, 1);
        idle_rows(0, 1);
        // A: backpressure on beat 2 with a second word waiting
        row(0, 1, 32'hCAFEF00D, 1, 0, 0, 0, 0,     0, 0);
        row(0, 0, 0,            1, 0, 1, 0, 0,     0, 0);
        row(0, 0, 0,            1, 0, 0, 1, 'h0D, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'hF0, 0, 1);
        row(0, 1, 32'h0BADBEEF, 0, 0, 0, 1, 'hFE, 0, 1);
        row(0, 0, 0,            0, 0, 0, 1, 'hFE, 0, 1);
        row(0, 0, 0,            0, 0, 0, 1, 'hFE, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'hFE, 0, 1);
        row(0, 0, 0,            1, 0, 1, 1, 'hCA, 1, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'hEF, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'hBE, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'hAD, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h0B, 1, 1);
        // A: empty FIFO idles quietly
        idle_rows(0, 10);
        // A: clear on beat 1, next word restarts at beat 0
        row(0, 1, 32'h01020304, 1, 0, 0, 0, 0,     0, 0);
        row(0, 1, 32'h05060708, 1, 0, 1, 0, 0,     0, 0);
        row(0, 0, 0,            1, 0, 0, 1, 'h04, 0, 1);
        row(0, 0, 0,            1, 1, 0, 1, 'h03, 0, 1);
        row(0, 0, 0,            1, 0, 1, 0, 0,     0, 0);
        row(0, 0, 0,            1, 0, 0, 1, 'h08, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h07, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h06, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h05, 1, 1);
        idle_rows(0, 1);
        // A: clear in idle blocks a pending pop
        row(0, 1, 32'h00000009, 1, 0, 0, 0, 0,     0, 0);
        row(0, 0, 0,            1, 1, 0, 0, 0,     0, 0);
        row(0, 0, 0,            1, 0, 1, 0, 0,     0, 0);
        row(0, 0, 0,            1, 0, 0, 1, 'h09, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h00, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h00, 0, 1);
        row(0, 0, 0,            1, 0, 0, 1, 'h00, 1, 1);
        idle_rows(0, 1);
        // B: sync-read FIFO, MSB first, one wait cycle per word
        row(1, 1, 32'hAABBCCDD, 1, 0, 0, 0, 0,     0, 0);
        row(1, 1, 32'h11223344, 1, 0, 1, 0, 0,     0, 0);
        row(1, 0, 0,            1, 0, 0, 0, 0,     0, 1);
        row(1, 0, 0,            1, 0, 0, 1, 'hAA, 0, 1);
        row(1, 0, 0,            1, 0, 0, 1, 'hBB, 0, 1);
        row(1, 0, 0,            1, 0, 0, 1, 'hCC, 0, 1);
        row(1, 0, 0,            1, 0, 1, 1, 'hDD, 1, 1);
        row(1, 0, 0,            1, 0, 0, 0, 0,     0, 1);
        row(1, 0, 0,            1, 0, 0, 1, 'h11, 0, 1);
        row(1, 0, 0,            1, 0, 0, 1, 'h22, 0, 1);
        row(1, 0, 0,            1, 0, 0, 1, 'h33, 0, 1);
        row(1, 0, 0,            1, 0, 0, 1, 'h44, 1, 1);
        idle_rows(1, 1);
        // B: clear during the wait cycle drops the popped word
        row(1, 1, 32'h55667788, 1, 0, 0, 0, 0,     0, 0);
        row(1, 0, 0,            1, 0, 1, 0, 0,     0, 0);
        row(1, 0, 0,            1, 1, 0, 0, 0,     0, 1);
        idle_rows(1, 2);

        // reset state, with C seeing data available while still in reset
        repeat (2) @(negedge clk);
        #1;
        chk("rst re_c", 32'(rec), 0);
        chk("rst valid_c", 32'(vc), 0);
        chk("rst last_c", 32'(lc), 0);
        chk("rst busy_c", 32'(bc), 0);
        chk("rst data_c", 32'(tc), 0);
        chk("rst valid_a", 32'(va), 0);
        chk("rst data_a", 32'(ta), 0);
        chk("rst busy_b", 32'(bb), 0);
        @(negedge clk);
        avc = 0;
        rstn = 1;

        foreach (vt[i]) begin
            @(negedge clk);
            pa = !vt[i].sel && vt[i].push;
            pb = vt[i].sel && vt[i].push;
            da = vt[i].pd;
            db = vt[i].pd;
            rdy_a = vt[i].rdy;
            rdy_b = vt[i].rdy;
            clr_a = !vt[i].sel && vt[i].clr;
            clr_b = vt[i].sel && vt[i].clr;
            #1;
            chk($sformatf("v%0d re", i), 32'(vt[i].sel ? re_b : re_a), 32'(vt[i].e_re));
            chk($sformatf("v%0d valid", i), 32'(vt[i].sel ? vb : va), 32'(vt[i].e_v));
            chk($sformatf("v%0d last", i), 32'(vt[i].sel ? lb : la), 32'(vt[i].e_l));
            chk($sformatf("v%0d busy", i), 32'(vt[i].sel ? bb : ba), 32'(vt[i].e_b));
            if (vt[i].e_v) chk($sformatf("v%0d data", i), 32'(vt[i].sel ? tb_d : ta), 32'(vt[i].e_d));
        end
        @(negedge clk);
        pa = 0; pb = 0; clr_a = 0; clr_b = 0;

        // C: one beat per word, every beat is last
        @(negedge clk);
        avc = 1; rdc = 16'h1234; rdyc = 1;
        #1;
        chk("c pop1", 32'(rec), 1);
        chk("c idle valid", 32'(vc), 0);
        @(negedge clk);
        rdc = 16'h5678;
        #1;
        chk("c beat1 valid", 32'(vc), 1);
        chk("c beat1 data", 32'(tc), 32'h1234);
        chk("c beat1 last", 32'(lc), 1);
        chk("c pop2", 32'(rec), 1);
        @(negedge clk);
        avc = 0;
        #1;
        chk("c beat2 data", 32'(tc), 32'h5678);
        chk("c beat2 last", 32'(lc), 1);
        chk("c beat2 re", 32'(rec), 0);
        @(negedge clk);
        #1;
        chk("c end valid", 32'(vc), 0);
        chk("c end busy", 32'(bc), 0);

        // C: async reset while a beat is stalled
        @(negedge clk);
        avc = 1; rdc = 16'hABCD;
        #1;
        chk("c pop3", 32'(rec), 1);
        @(negedge clk);
        rdyc = 0;
        #1;
        chk("c stall valid", 32'(vc), 1);
        chk("c stall data", 32'(tc), 32'hABCD);
        chk("c stall re", 32'(rec), 0);
        #2 rstn = 0;
        #1;
        chk("c arst valid", 32'(vc), 0);
        chk("c arst data", 32'(tc), 0);
        chk("c arst last", 32'(lc), 0);
        chk("c arst busy", 32'(bc), 0);
        chk("c arst re", 32'(rec), 0);
        @(negedge clk);
        #1;
        chk("c arst hold re", 32'(rec), 0);
        @(negedge clk);
        rstn = 1; avc = 0; rdyc = 1;
        @(negedge clk);
        #1;
        chk("c post busy", 32'(bc), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
